// File: rtl/div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per clock; divide-by-zero and signed overflow resolve in one cycle.
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             kill,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             rem_sel_q, rem_sel_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;

    logic             signed_op;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_sub;

    // Operand conditioning: signed ops divide magnitudes and fix signs at the end
    always_comb begin
        signed_op = ~op[0];
        a_neg     = signed_op & A[WIDTH-1];
        b_neg     = signed_op & B[WIDTH-1];
        a_mag     = a_neg ? (WIDTH'(0) - A) : A;
        b_mag     = b_neg ? (WIDTH'(0) - B) : B;
        rem_sh    = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        rem_sub   = rem_sh - {1'b0, div_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            rem_sel_q <= 1'b0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            div_q     <= div_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            rem_sel_q <= rem_sel_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        div_d     = div_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        rem_sel_d = rem_sel_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;

        unique case (state_q)
            S_IDLE: begin
                if (start && !kill) begin
                    rem_sel_d = op[1];
                    cnt_d     = '0;
                    if (B == '0) begin
                        result_d = op[1] ? A : '1;
                        state_d  = S_DONE;
                    end else if (signed_op && (A == MIN_NEG) && (B == '1)) begin
                        result_d = op[1] ? '0 : MIN_NEG;
                        state_d  = S_DONE;
                    end else begin
                        rem_d   = '0;
                        quo_d   = a_mag;
                        div_d   = b_mag;
                        q_neg_d = a_neg ^ b_neg;
                        r_neg_d = a_neg;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
                    // Remainder is one bit wider so the shifted value never overflows the compare
                    if (rem_sh >= {1'b0, div_q}) begin
                        rem_d = rem_sub;
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = rem_sh;
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH-1)) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
                    if (rem_sel_q) begin
                        result_d = r_neg_q ? (WIDTH'(0) - rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
                    end else begin
                        result_d = q_neg_q ? (WIDTH'(0) - quo_q) : quo_q;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: scoreboard of expected results popped on each done pulse.
module tb_div_unit;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             kill;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    int n_cmp;
    int n_err;
    int done_cnt;
    logic [WIDTH-1:0] exp_q[$];

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    div_unit #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .A      (A),
        .B      (B),
        .kill   (kill),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation, wait for done, compare against the scoreboard head.
    task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                       input bit poke);
        int lat;
        int bcnt;
        bit got;
        logic [31:0] e;
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        start = 1'b0;
        lat  = 0;
        bcnt = busy ? 1 : 0;
        got  = done;
        while (!got && lat < 100) begin
            if (poke && lat == 5) begin
                start = 1'b1; op = OP_DIVU; A = 32'd3; B = 32'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
            if (busy) bcnt++;
            if (done) got = 1'b1;
        end
        start = 1'b0;
        if (!got) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            void'(exp_q.pop_front());
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_result"}, result, e);
            chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
            chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(exp_lat + 1));
        end
        @(posedge clk); #1;
        chk({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int d0;
        n_cmp = 0; n_err = 0; done_cnt = 0;
        rst_n = 1'b0; start = 1'b0; kill = 1'b0; op = 2'b00; A = '0; B = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_result", result, 32'd0);

        run("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b0);
        run("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 33, 1'b0);
        run("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0);
        run("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b0);
        run("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 1'b0);
        run("div_m100_m7", OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 33, 1'b0);
        run("div_5_0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 1'b0);
        run("remu_5_0", OP_REMU, 32'd5, 32'd0, 32'd5, 0, 1'b0);
        run("rem_m7_0", OP_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 0, 1'b0);
        run("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1'b0);
        run("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 1'b0);
        run("divu_minneg_m1", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, 1'b0);

        d0 = done_cnt;
        run("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 1'b1);
        repeat (40) @(posedge clk);
        #1;
        chk("poke_single_done", 32'(done_cnt - d0), 32'd1);
        chk("poke_result_held", result, 32'hFFFF_FFFF);

        // kill together with start in IDLE drops the start
        @(negedge clk);
        start = 1'b1; kill = 1'b1; op = OP_DIVU; A = 32'd50; B = 32'd5;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        chk("kill_start_busy", {31'd0, busy}, 32'd0);

        // kill mid-CALC
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; A = 32'd100; B = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        chk("kill_busy", {31'd0, busy}, 32'd0);
        chk("kill_done", {31'd0, done}, 32'd0);
        chk("kill_result_held", result, 32'hFFFF_FFFF);
        run("after_kill", OP_DIVU, 32'd1000, 32'd10, 32'd100, 33, 1'b0);
        chk("kill_done_count", 32'(done_cnt - d0), 32'd1);

        // asynchronous reset mid-CALC
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; A = 32'd100; B = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_busy", {31'd0, busy}, 32'd0);
        chk("areset_done", {31'd0, done}, 32'd0);
        chk("areset_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run("after_reset", OP_DIVU, 32'd9, 32'd3, 32'd3, 33, 1'b0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
